// File: rtl/pio_ctrl_pkg.sv
// pio_ctrl_pkg: shared types and constants for the PIO command sequencer.
// Opcode and state encodings, result word field positions and the
// threshold value loaded at reset.
package pio_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_NOP      = 4'h0,
        OP_SET_ADDR = 4'h1,
        OP_WR_PIX   = 4'h2,
        OP_SET_THR  = 4'h3,
        OP_RUN      = 4'h4,
        OP_RD_RES   = 4'h5,
        OP_STATUS   = 4'h6
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EXEC     = 3'd1,
        ST_ACK      = 3'd2,
        ST_WAIT_RD  = 3'd3,
        ST_WAIT_ENG = 3'd4
    } state_e;

    localparam int ACK_BIT = 31;
    localparam int ERR_BIT = 30;
    localparam int DATA_W  = 30;

    localparam logic [DATA_W-1:0] DATA_MAX  = 30'h3FFF_FFFF;
    localparam logic [7:0]        THR_RESET = 8'h40;

    // Assemble the word presented on the data-out PIO.
    function automatic logic [31:0] pack_result(input logic ack,
                                                input logic err,
                                                input logic [DATA_W-1:0] data);
        return {ack, err, data};
    endfunction

endpackage

// File: rtl/pio_cmd_ctrl_run_timer.sv
// run_timer: saturating 30-bit cycle counter for engine runs.
// With PIO_CTRL_WATCHDOG_EN defined, also flags when the count being
// recorded this cycle reaches TIMEOUT_CYCLES; otherwise never expires.
module run_timer
    import pio_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clr,
    input  logic              i_en,
    output logic [DATA_W-1:0] o_cnt_next,
    output logic              o_expired
);

    logic [DATA_W-1:0] r_cnt;

    // Next count value, sticking at the all-ones ceiling.
    always_comb begin
        if (r_cnt == DATA_MAX) begin
            o_cnt_next = DATA_MAX;
        end else begin
            o_cnt_next = r_cnt + 30'd1;
        end
    end

    // Counter register: clear takes priority over counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 30'd0;
        end else if (i_clr) begin
            r_cnt <= 30'd0;
        end else if (i_en) begin
            r_cnt <= o_cnt_next;
        end else begin
            r_cnt <= r_cnt;
        end
    end

`ifdef PIO_CTRL_WATCHDOG_EN
    localparam logic [DATA_W-1:0] LIMIT = 30'(TIMEOUT_CYCLES);

    // Watchdog compare on the count that would be recorded this cycle.
    always_comb begin
        o_expired = i_en && (o_cnt_next >= LIMIT);
    end
`else
    // Without the watchdog the engine is waited on indefinitely.
    always_comb begin
        o_expired = 1'b0;
    end
`endif

endmodule

// File: rtl/pio_cmd_ctrl.sv
// pio_cmd_ctrl: decodes 20-bit HPS command words and runs a four-phase
// flag/ack handshake, driving pixel writes, threshold config, engine
// runs and result readback. Optional watchdog: PIO_CTRL_WATCHDOG_EN.
module pio_cmd_ctrl
    import pio_ctrl_pkg::*;
#(
    parameter int ADDR_W         = 14,
    parameter int TIMEOUT_CYCLES = 1000000
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic [19:0]       cmd_i,
    input  logic              flag_i,
    output logic [31:0]       result_o,
    output logic [ADDR_W-1:0] pix_addr_o,
    output logic [7:0]        pix_wdata_o,
    output logic              pix_we_o,
    output logic [ADDR_W-1:0] res_addr_o,
    input  logic [7:0]        res_rdata_i,
    output logic [7:0]        thresh_o,
    output logic              eng_start_o,
    input  logic              eng_done_i,
    output logic              eng_abort_o
);

    logic              r_flag_q;
    logic              r_flag_q2;
    state_e            r_state;
    logic [19:0]       r_cmd;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_thr;
    logic              r_timeout;
    logic [31:0]       r_result;
    logic [ADDR_W-1:0] r_pix_addr;
    logic [7:0]        r_pix_wdata;
    logic              r_pix_we;
    logic [ADDR_W-1:0] r_res_addr;
    logic              r_start;
    logic              r_abort;

    logic              w_flag_rise;
    logic [15:0]       w_arg;
    logic [ADDR_W-1:0] w_addr_inc;
    logic [13:0]       w_addr14;
    logic              w_tmr_clr;
    logic              w_tmr_en;
    logic [DATA_W-1:0] w_cnt_next;
    logic              w_expired;

    assign w_flag_rise = r_flag_q & ~r_flag_q2;
    assign w_arg       = r_cmd[15:0];
    assign w_addr_inc  = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign w_addr14    = 14'(r_addr);
    assign w_tmr_clr   = (r_state == ST_EXEC) && (r_cmd[19:16] == OP_RUN);
    assign w_tmr_en    = (r_state == ST_WAIT_ENG);

    assign result_o    = r_result;
    assign pix_addr_o  = r_pix_addr;
    assign pix_wdata_o = r_pix_wdata;
    assign pix_we_o    = r_pix_we;
    assign res_addr_o  = r_res_addr;
    assign thresh_o    = r_thr;
    assign eng_start_o = r_start;
    assign eng_abort_o = r_abort;

    run_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_run_timer (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (w_tmr_clr),
        .i_en       (w_tmr_en),
        .o_cnt_next (w_cnt_next),
        .o_expired  (w_expired)
    );

    // Register the HPS flag twice so a rising edge can be detected.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flag_q  <= 1'b0;
            r_flag_q2 <= 1'b0;
        end else begin
            r_flag_q  <= flag_i;
            r_flag_q2 <= r_flag_q;
        end
    end

    // Command FSM with all outputs registered; strobes default low each cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cmd       <= 20'd0;
            r_addr      <= {ADDR_W{1'b0}};
            r_thr       <= THR_RESET;
            r_timeout   <= 1'b0;
            r_result    <= 32'd0;
            r_pix_addr  <= {ADDR_W{1'b0}};
            r_pix_wdata <= 8'd0;
            r_pix_we    <= 1'b0;
            r_res_addr  <= {ADDR_W{1'b0}};
            r_start     <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_pix_we <= 1'b0;
            r_start  <= 1'b0;
            r_abort  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_flag_rise) begin
                        r_cmd   <= cmd_i;
                        r_state <= ST_EXEC;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    case (opcode_e'(r_cmd[19:16]))
                        OP_NOP: begin
                            r_result <= pack_result(1'b1, 1'b0, 30'd0);
                            r_state  <= ST_ACK;
                        end
                        OP_SET_ADDR: begin
                            r_addr   <= w_arg[ADDR_W-1:0];
                            r_result <= pack_result(1'b1, 1'b0, 30'd0);
                            r_state  <= ST_ACK;
                        end
                        OP_WR_PIX: begin
                            r_pix_we    <= 1'b1;
                            r_pix_addr  <= r_addr;
                            r_pix_wdata <= w_arg[7:0];
                            r_addr      <= w_addr_inc;
                            r_result    <= pack_result(1'b1, 1'b0, 30'd0);
                            r_state     <= ST_ACK;
                        end
                        OP_SET_THR: begin
                            r_thr    <= w_arg[7:0];
                            r_result <= pack_result(1'b1, 1'b0, 30'd0);
                            r_state  <= ST_ACK;
                        end
                        OP_RUN: begin
                            r_start   <= 1'b1;
                            r_timeout <= 1'b0;
                            r_state   <= ST_WAIT_ENG;
                        end
                        OP_RD_RES: begin
                            r_res_addr <= r_addr;
                            r_addr     <= w_addr_inc;
                            r_state    <= ST_WAIT_RD;
                        end
                        OP_STATUS: begin
                            r_result <= pack_result(1'b1, 1'b0,
                                            {w_addr14, r_thr, 7'd0, r_timeout});
                            r_state  <= ST_ACK;
                        end
                        default: begin
                            r_result <= pack_result(1'b1, 1'b1, 30'd0);
                            r_state  <= ST_ACK;
                        end
                    endcase
                end
                ST_WAIT_RD: begin
                    r_result <= pack_result(1'b1, 1'b0, {22'd0, res_rdata_i});
                    r_state  <= ST_ACK;
                end
                ST_WAIT_ENG: begin
                    if (eng_done_i) begin
                        r_result <= pack_result(1'b1, 1'b0, w_cnt_next);
                        r_state  <= ST_ACK;
                    end else if (w_expired) begin
                        r_abort   <= 1'b1;
                        r_timeout <= 1'b1;
                        r_result  <= pack_result(1'b1, 1'b1, DATA_MAX);
                        r_state   <= ST_ACK;
                    end else begin
                        r_state <= ST_WAIT_ENG;
                    end
                end
                ST_ACK: begin
                    if (!r_flag_q) begin
                        r_result[ACK_BIT] <= 1'b0;
                        r_state           <= ST_IDLE;
                    end else begin
                        r_state <= ST_ACK;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pio_cmd_ctrl.sv
// tb_pio_cmd_ctrl: directed bench for pio_cmd_ctrl with hand-computed
// expectations. Watchdog scenario compiled with PIO_CTRL_WATCHDOG_EN.
module tb_pio_cmd_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] cmd_i = 20'd0;
    logic        flag_i = 1'b0;
    logic [31:0] result_o;
    logic [13:0] pix_addr_o;
    logic [7:0]  pix_wdata_o;
    logic        pix_we_o;
    logic [13:0] res_addr_o;
    logic [7:0]  res_rdata_i;
    logic [7:0]  thresh_o;
    logic        eng_start_o;
    logic        eng_done_i = 1'b0;
    logic        eng_abort_o;

    int n_pass = 0;
    int n_total = 0;
    int n_abort = 0;
    int n_start = 0;
    logic [13:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];

    always #5 clk = ~clk;

    // result memory model: data = low address byte XOR 0x7B (addr 5 -> 0x7E)
    assign res_rdata_i = res_addr_o[7:0] ^ 8'h7B;

    pio_cmd_ctrl #(
        .ADDR_W         (14),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_i       (cmd_i),
        .flag_i      (flag_i),
        .result_o    (result_o),
        .pix_addr_o  (pix_addr_o),
        .pix_wdata_o (pix_wdata_o),
        .pix_we_o    (pix_we_o),
        .res_addr_o  (res_addr_o),
        .res_rdata_i (res_rdata_i),
        .thresh_o    (thresh_o),
        .eng_start_o (eng_start_o),
        .eng_done_i  (eng_done_i),
        .eng_abort_o (eng_abort_o)
    );

    always @(posedge clk) begin
        if (pix_we_o) begin
            wr_addr_q.push_back(pix_addr_o);
            wr_data_q.push_back(pix_wdata_o);
        end
        if (eng_abort_o) n_abort <= n_abort + 1;
        if (eng_start_o) n_start <= n_start + 1;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout reached at %0t", $time);
        $fatal(1);
    end

    // Raise the flag with a command; lat = negedges until ack seen (0 = none).
    task automatic issue(input logic [19:0] cmd, input int limit, output int lat);
        @(negedge clk);
        cmd_i = cmd;
        flag_i = 1'b1;
        lat = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (i == 2) cmd_i = 20'hFFFFF;
            if (result_o[31]) begin
                lat = i;
                break;
            end
        end
    endtask

    // Drop the flag; lat = negedges until ack clears (0 = never).
    task automatic release_flag(output int lat);
        flag_i = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (!result_o[31]) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if (result_o !== 32'd0 || pix_we_o !== 1'b0 || eng_start_o !== 1'b0 ||
            eng_abort_o !== 1'b0 || pix_addr_o !== 14'd0 || res_addr_o !== 14'd0) begin
            $display("FAIL reset_outputs got res=%h we=%b st=%b ab=%b pa=%h ra=%h exp all zero",
                     result_o, pix_we_o, eng_start_o, eng_abort_o, pix_addr_o, res_addr_o);
        end else n_pass++;
        n_total++;
        if (thresh_o !== 8'h40) $display("FAIL reset_thresh got %h exp 40", thresh_o);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_status;
        int lat;
        issue(20'h60000, 20, lat);
        n_total++;
        if (lat !== 3) $display("FAIL status_latency got %0d exp 3", lat);
        else n_pass++;
        n_total++;
        if (result_o !== 32'h8000_4000) $display("FAIL status_result got %h exp 80004000", result_o);
        else n_pass++;
        release_flag(lat);
        n_total++;
        if (lat !== 2) $display("FAIL ack_release_latency got %0d exp 2", lat);
        else n_pass++;
        n_total++;
        if (result_o !== 32'h0000_4000) $display("FAIL data_hold_after_ack got %h exp 00004000", result_o);
        else n_pass++;
    endtask

    task automatic test_wr_pix;
        int lat;
        wr_addr_q.delete();
        wr_data_q.delete();
        issue(20'h13FFF, 20, lat);
        n_total++;
        if (lat !== 3 || result_o[31:30] !== 2'b10)
            $display("FAIL set_addr_ack got lat=%0d bits=%b exp lat=3 bits=10", lat, result_o[31:30]);
        else n_pass++;
        release_flag(lat);
        issue(20'h200AB, 20, lat);
        release_flag(lat);
        issue(20'h200CD, 20, lat);
        release_flag(lat);
        n_total++;
        if (wr_addr_q.size() !== 2) $display("FAIL wr_pix_count got %0d exp 2", wr_addr_q.size());
        else n_pass++;
        if (wr_addr_q.size() == 2) begin
            n_total++;
            if (wr_addr_q[0] !== 14'h3FFF || wr_data_q[0] !== 8'hAB)
                $display("FAIL wr_pix_first got (%h,%h) exp (3fff,ab)", wr_addr_q[0], wr_data_q[0]);
            else n_pass++;
            n_total++;
            if (wr_addr_q[1] !== 14'h0000 || wr_data_q[1] !== 8'hCD)
                $display("FAIL wr_pix_wrap got (%h,%h) exp (0000,cd)", wr_addr_q[1], wr_data_q[1]);
            else n_pass++;
        end
        issue(20'h60000, 20, lat);
        n_total++;
        if (result_o !== 32'h8001_4000) $display("FAIL status_after_wrap got %h exp 80014000", result_o);
        else n_pass++;
        release_flag(lat);
    endtask

    task automatic test_set_thr;
        int lat;
        issue(20'h30022, 20, lat);
        release_flag(lat);
        n_total++;
        if (thresh_o !== 8'h22) $display("FAIL set_thr got %h exp 22", thresh_o);
        else n_pass++;
        issue(20'h60000, 20, lat);
        n_total++;
        if (result_o !== 32'h8001_2200) $display("FAIL status_thr got %h exp 80012200", result_o);
        else n_pass++;
        release_flag(lat);
    endtask

    task automatic test_run;
        int lat;
        int seen;
        bit early;
        int writes0;
        int starts0;
        writes0 = wr_addr_q.size();
        starts0 = n_start;
        // a stray done in IDLE must not produce an ack
        @(negedge clk);
        eng_done_i = 1'b1;
        @(negedge clk);
        eng_done_i = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if (result_o[31] !== 1'b0) $display("FAIL done_in_idle got ack=%b exp 0", result_o[31]);
        else n_pass++;
        // RUN: flag up before C0
        cmd_i = 20'h40000;
        flag_i = 1'b1;
        seen = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (eng_start_o) begin
                seen = i;
                break;
            end
        end
        n_total++;
        if (seen !== 3) $display("FAIL run_start_cycle got %0d exp 3", seen);
        else n_pass++;
        early = 1'b0;
        for (int c = 3; c <= 11; c++) begin
            @(negedge clk);
            if (c == 3) begin
                flag_i = 1'b0;
                n_total++;
                if (eng_start_o !== 1'b0) $display("FAIL run_start_width got %b exp 0", eng_start_o);
                else n_pass++;
            end
            if (c == 5) begin
                flag_i = 1'b1;
                cmd_i = 20'h200EE;
            end
            if (result_o[31]) early = 1'b1;
        end
        eng_done_i = 1'b1;
        @(negedge clk);
        eng_done_i = 1'b0;
        n_total++;
        if (early) $display("FAIL run_early_ack got ack before done exp none");
        else n_pass++;
        n_total++;
        if (result_o !== 32'h8000_000A) $display("FAIL run_cycles got %h exp 8000000a", result_o);
        else n_pass++;
        release_flag(lat);
        repeat (3) @(negedge clk);
        n_total++;
        if (wr_addr_q.size() !== writes0 || n_start !== starts0 + 1)
            $display("FAIL run_second_edge got writes=%0d starts=%0d exp writes=%0d starts=%0d",
                     wr_addr_q.size(), n_start, writes0, starts0 + 1);
        else n_pass++;
    endtask

    task automatic test_rd_res;
        int lat;
        issue(20'h10005, 20, lat);
        release_flag(lat);
        issue(20'h50005, 20, lat);
        n_total++;
        if (lat !== 4) $display("FAIL rd_res_latency got %0d exp 4", lat);
        else n_pass++;
        n_total++;
        if (result_o !== 32'h8000_007E) $display("FAIL rd_res_data got %h exp 8000007e", result_o);
        else n_pass++;
        n_total++;
        if (res_addr_o !== 14'd5) $display("FAIL rd_res_addr got %h exp 0005", res_addr_o);
        else n_pass++;
        release_flag(lat);
        issue(20'h60000, 20, lat);
        n_total++;
        if (result_o !== 32'h8006_2200) $display("FAIL status_after_rd got %h exp 80062200", result_o);
        else n_pass++;
        release_flag(lat);
    endtask

    task automatic test_illegal;
        int lat;
        issue(20'h90000, 20, lat);
        n_total++;
        if (lat !== 3 || result_o !== 32'hC000_0000)
            $display("FAIL illegal_op got lat=%0d res=%h exp lat=3 res=c0000000", lat, result_o);
        else n_pass++;
        release_flag(lat);
        n_total++;
        if (result_o !== 32'h4000_0000) $display("FAIL illegal_after_ack got %h exp 40000000", result_o);
        else n_pass++;
    endtask

`ifdef PIO_CTRL_WATCHDOG_EN
    task automatic test_watchdog;
        int lat;
        int aborts0;
        aborts0 = n_abort;
        issue(20'h40000, 200, lat);
        n_total++;
        if (lat !== 53) $display("FAIL wdog_latency got %0d exp 53", lat);
        else n_pass++;
        n_total++;
        if (result_o !== 32'hFFFF_FFFF) $display("FAIL wdog_result got %h exp ffffffff", result_o);
        else n_pass++;
        release_flag(lat);
        n_total++;
        if (n_abort !== aborts0 + 1) $display("FAIL wdog_abort_pulses got %0d exp %0d", n_abort, aborts0 + 1);
        else n_pass++;
        issue(20'h60000, 20, lat);
        n_total++;
        if (result_o !== 32'h8006_2201) $display("FAIL wdog_status got %h exp 80062201", result_o);
        else n_pass++;
        release_flag(lat);
        // a successful RUN clears the timeout flag; done at C4 gives data 2
        @(negedge clk);
        cmd_i = 20'h40000;
        flag_i = 1'b1;
        repeat (4) @(negedge clk);
        eng_done_i = 1'b1;
        @(negedge clk);
        eng_done_i = 1'b0;
        n_total++;
        if (result_o !== 32'h8000_0002) $display("FAIL wdog_rerun got %h exp 80000002", result_o);
        else n_pass++;
        release_flag(lat);
        issue(20'h60000, 20, lat);
        n_total++;
        if (result_o !== 32'h8006_2200) $display("FAIL wdog_cleared got %h exp 80062200", result_o);
        else n_pass++;
        release_flag(lat);
    endtask
`else
    task automatic test_watchdog;
        int lat;
        n_total++;
        if (n_abort !== 0) $display("FAIL abort_tied_low got %0d pulses exp 0", n_abort);
        else n_pass++;
        issue(20'h60000, 20, lat);
        n_total++;
        if (result_o !== 32'h8006_2200) $display("FAIL timeout_flag_low got %h exp 80062200", result_o);
        else n_pass++;
        release_flag(lat);
    endtask
`endif

    task automatic test_reset_mid;
        int lat;
        @(negedge clk);
        cmd_i = 20'h40000;
        flag_i = 1'b1;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_total++;
        if (result_o !== 32'd0 || thresh_o !== 8'h40 || eng_start_o !== 1'b0)
            $display("FAIL reset_mid got res=%h thr=%h st=%b exp 0/40/0", result_o, thresh_o, eng_start_o);
        else n_pass++;
        reset = 1'b0;
        flag_i = 1'b0;
        repeat (2) @(negedge clk);
        issue(20'h00000, 20, lat);
        n_total++;
        if (lat !== 3 || result_o !== 32'h8000_0000)
            $display("FAIL nop_after_reset got lat=%0d res=%h exp lat=3 res=80000000", lat, result_o);
        else n_pass++;
        release_flag(lat);
        issue(20'h60000, 20, lat);
        n_total++;
        if (result_o !== 32'h8000_4000) $display("FAIL status_after_reset got %h exp 80004000", result_o);
        else n_pass++;
        release_flag(lat);
    endtask

    initial begin
        test_reset();
        test_status();
        test_wr_pix();
        test_set_thr();
        test_run();
        test_rd_res();
        test_illegal();
        test_watchdog();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
